// File: rtl/second_layer_tnndirect.sv
// second_layer_tnndirect: ternary-weight second layer, serial accumulate then serial argmax, one inference per reset
module second_layer_tnndirect #(
  parameter int HIDDEN_CNT = 4,
  parameter int CLASS_CNT = 3,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] SPARSE_VALS = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] MASK = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [HIDDEN_CNT-1:0] hidden,
  input  logic start,
  output logic [$clog2(CLASS_CNT)-1:0] out,
  output logic done
);
  localparam int SW = $clog2(HIDDEN_CNT+1)+1;
  localparam int CW = $clog2((HIDDEN_CNT > CLASS_CNT ? HIDDEN_CNT : CLASS_CNT)+1);
  localparam int OW = $clog2(CLASS_CNT);
  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [HIDDEN_CNT-1:0] hid_q, sel;
  logic signed [SW-1:0] score [CLASS_CNT];
  logic signed [SW-1:0] best_score, cur_score;
  logic [OW-1:0] best_idx, win_idx;
  logic [CLASS_CNT-1:0] m, s;
  logic hbit, last_h, last_c, take;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state; DONE is terminal until reset
  always_comb
    nxt = state == IDLE   ? (start ? ACCUM : IDLE) :
          state == ACCUM  ? (last_h ? ARGMAX : ACCUM) :
          state == ARGMAX ? (last_c ? DONE : ARGMAX) : DONE;
  // per-step decode: current hidden bit, per-class weight, current class score and argmax candidate
  always_comb begin
    sel = HIDDEN_CNT'(1) << cnt;
    hbit = |(hid_q & sel);
    cur_score = score[0];
    for (int c = 0; c < CLASS_CNT; c++) begin
      m[c] = |(MASK[c*HIDDEN_CNT +: HIDDEN_CNT] & sel);
      s[c] = |(SPARSE_VALS[c*HIDDEN_CNT +: HIDDEN_CNT] & sel);
      if (cnt == CW'(c)) cur_score = score[c];
    end
    take = cnt == '0 || cur_score > best_score;
    win_idx = take ? OW'(cnt) : best_idx;
    last_h = cnt == CW'(HIDDEN_CNT-1);
    last_c = cnt == CW'(CLASS_CNT-1);
  end
  // datapath: latch input, accumulate ternary terms, track running best, publish result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      hid_q <= '0;
      best_score <= '0;
      best_idx <= '0;
      out <= '0;
      for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
    end else if (state == IDLE && start) begin
      hid_q <= hidden;
      cnt <= '0;
      for (int c = 0; c < CLASS_CNT; c++) score[c] <= '0;
    end else if (state == ACCUM) begin
      cnt <= last_h ? '0 : cnt + 1'b1;
      for (int c = 0; c < CLASS_CNT; c++)
        if (m[c]) score[c] <= score[c] + (s[c] == hbit ? SW'(1) : {SW{1'b1}});
    end else if (state == ARGMAX) begin
      cnt <= last_c ? '0 : cnt + 1'b1;
      best_score <= take ? cur_score : best_score;
      best_idx <= win_idx;
      if (last_c) out <= win_idx;
    end
endmodule

// File: tb/tb_second_layer_tnndirect.sv
// tb_second_layer_tnndirect: directed checks of scoring, argmax ties, latency, reset and input isolation
module tb_second_layer_tnndirect;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] hidden = '0;
  logic [1:0] out, out2;
  logic done, done2;
  int pass = 0, total = 0;

  second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .SPARSE_VALS(12'hA0F), .MASK(12'hFFF)) dut (
    .clk(clk), .rst(rst), .hidden(hidden), .start(start), .out(out), .done(done));
  second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .SPARSE_VALS(12'hA0F), .MASK(12'hF0F)) dut2 (
    .clk(clk), .rst(rst), .hidden(hidden), .start(start), .out(out2), .done(done2));

  always #5 clk = ~clk;

  task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1;
    #1;
    chk(8'(done), 8'd0, "rst_done");
    chk(8'(out), 8'd0, "rst_out");
    @(negedge clk);
    rst = 0;
  endtask

  task automatic lat_check(input logic [3:0] h, input logic [1:0] e, input string tag);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 0;
        hidden = ~h;
      end
      chk(8'(done), 8'd0, {tag, "_early"});
    end
    @(negedge clk);
    chk(8'(done), 8'd1, {tag, "_done"});
    chk(8'(out), 8'(e), {tag, "_out"});
  endtask

  task automatic go(input logic [3:0] h, input logic [1:0] e, input string tag);
    rst_pulse();
    hidden = h;
    start = 1;
    lat_check(h, e, tag);
  endtask

  initial begin
    #2;
    chk(8'(done), 8'd0, "por_done");
    chk(8'(out), 8'd0, "por_out");
    @(negedge clk);
    rst = 0;
    go(4'b1111, 2'd0, "h1111");
    go(4'b0000, 2'd1, "h0000");
    chk(8'(out2), 8'd1, "mask0_out");
    chk(8'(done2), 8'd1, "mask0_done");
    go(4'b1100, 2'd0, "tie");
    go(4'b0010, 2'd1, "tie12");
    go(4'b0101, 2'd0, "h0101");
    go(4'b1010, 2'd2, "h1010");
    start = 1;
    for (int i = 0; i < 20; i++) begin
      hidden = 4'(i);
      @(negedge clk);
      chk(8'(done), 8'd1, "hold_done");
      chk(8'(out), 8'd2, "hold_out");
    end
    start = 0;
    rst_pulse();
    hidden = 4'b1010;
    start = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk(8'(done), 8'd0, "mid_rst_done");
    chk(8'(out), 8'd0, "mid_rst_out");
    @(negedge clk);
    rst = 0;
    lat_check(4'b1010, 2'd2, "rerun");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
